// File: rtl/sd_spi_card_responder.sv
// SD-card SPI-mode responder: decodes host command frames on cs/sclk/mosi and answers
// on miso with R1/R3/R7, single-block read data and write handshakes over a byte memory.
module sd_spi_card_responder #(
   parameter int NUM_BLOCKS     = 64,
   parameter int MEM_AW         = 15,
   parameter int ACMD41_RETRIES = 2,
   parameter int BUSY_BYTES     = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cs,
   input  logic              sclk,
   input  logic              mosi,
   output logic              miso,
   output logic [MEM_AW-1:0] mem_addr,
   input  logic [7:0]        mem_rdata,
   output logic [7:0]        mem_wdata,
   output logic              mem_we,
   output logic              card_ready,
   output logic [5:0]        last_cmd,
   output logic [31:0]       debug
);

   typedef enum logic [3:0] {
      WAIT_CMD = 4'd0,  CMD_ARG  = 4'd1,  CMD_CRC = 4'd2,  NCR     = 4'd3,
      RESP     = 4'd4,  RD_TOKEN = 4'd5,  RD_DATA = 4'd6,  RD_CRC  = 4'd7,
      WR_WAIT  = 4'd8,  WR_DATA  = 4'd9,  WR_CRC  = 4'd10, WR_RESP = 4'd11,
      WR_BUSY  = 4'd12
   } state_e;

   function automatic logic [MEM_AW-1:0] blk_addr(input logic [22:0] blk, input logic [9:0] cnt);
      logic [MEM_AW-1:0] a;
      a = MEM_AW'({blk, 9'd0}) + MEM_AW'(cnt);
      return a;
   endfunction

   logic sclk_meta_q, sclk_sync_q, sclk_prev_q;
   logic cs_meta_q, cs_sync_q, mosi_meta_q, mosi_sync_q;

   state_e            state_q, state_d;
   logic [2:0]        bit_cnt_q, bit_cnt_d;
   logic [6:0]        rx_shift_q, rx_shift_d;
   logic [7:0]        tx_shift_q, tx_shift_d;
   logic              miso_q, miso_d;
   logic [9:0]        byte_cnt_q, byte_cnt_d;
   logic [5:0]        cmd_q, cmd_d;
   logic [31:0]       arg_q, arg_d;
   logic [31:0]       ext_q, ext_d;
   logic              has_ext_q, has_ext_d;
   logic              data_ok_q, data_ok_d;
   logic              app_q, app_d;
   logic              idle_q, idle_d;
   logic              ready_q, ready_d;
   logic [7:0]        retry_q, retry_d;
   logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
   logic [7:0]        mem_wdata_q, mem_wdata_d;
   logic              mem_we_q, mem_we_d;

   logic       rise_s, fall_s, byte_done_s;
   logic [7:0] rx_byte_s, tx_load_s;

   assign rise_s    = sclk_sync_q & ~sclk_prev_q;
   assign fall_s    = ~sclk_sync_q & sclk_prev_q;
   assign rx_byte_s = {rx_shift_q, mosi_sync_q};

   // Bit layer plus byte-level protocol FSM; tx_load_s is the byte sent in the next slot.
   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      rx_shift_d  = rx_shift_q;
      tx_shift_d  = tx_shift_q;
      miso_d      = miso_q;
      byte_cnt_d  = byte_cnt_q;
      cmd_d       = cmd_q;
      arg_d       = arg_q;
      ext_d       = ext_q;
      has_ext_d   = has_ext_q;
      data_ok_d   = data_ok_q;
      app_d       = app_q;
      idle_d      = idle_q;
      ready_d     = ready_q;
      retry_d     = retry_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_we_d    = 1'b0;
      byte_done_s = 1'b0;
      tx_load_s   = 8'hFF;

      if (cs_sync_q) begin
         bit_cnt_d  = 3'd0;
         byte_cnt_d = 10'd0;
         state_d    = WAIT_CMD;
         miso_d     = 1'b1;
         tx_shift_d = 8'hFF;
      end else begin
         if (rise_s) begin
            rx_shift_d  = rx_byte_s[6:0];
            bit_cnt_d   = bit_cnt_q + 3'd1;
            byte_done_s = (bit_cnt_q == 3'd7);
         end else if (fall_s) begin
            miso_d     = tx_shift_q[7];
            tx_shift_d = {tx_shift_q[6:0], 1'b1};
         end else begin
            bit_cnt_d = bit_cnt_q;
         end

         if (byte_done_s) begin
            case (state_q)
               WAIT_CMD: begin
                  if (rx_byte_s[7:6] == 2'b01) begin
                     cmd_d      = rx_byte_s[5:0];
                     byte_cnt_d = 10'd0;
                     state_d    = CMD_ARG;
                  end else begin
                     state_d = WAIT_CMD;
                  end
               end
               CMD_ARG: begin
                  arg_d = {arg_q[23:0], rx_byte_s};
                  if (byte_cnt_q == 10'd3) begin
                     byte_cnt_d = 10'd0;
                     state_d    = CMD_CRC;
                  end else begin
                     byte_cnt_d = byte_cnt_q + 10'd1;
                  end
               end
               CMD_CRC: state_d = NCR;
               NCR: begin
                  state_d    = RESP;
                  byte_cnt_d = 10'd0;
                  has_ext_d  = 1'b0;
                  ext_d      = 32'd0;
                  data_ok_d  = 1'b0;
                  app_d      = 1'b0;
                  tx_load_s  = {7'd0, idle_q};
                  case (cmd_q)
                     6'd0: begin
                        idle_d    = 1'b1;
                        ready_d   = 1'b0;
                        retry_d   = 8'd0;
                        tx_load_s = 8'h01;
                     end
                     6'd8: begin
                        has_ext_d = 1'b1;
                        ext_d     = {16'h0000, 8'h01, arg_q[7:0]};
                     end
                     6'd55: app_d = 1'b1;
                     6'd41: begin
                        if (!app_q) begin
                           tx_load_s = {5'd0, 1'b1, 1'b0, idle_q};
                        end else if (retry_q < 8'(ACMD41_RETRIES)) begin
                           retry_d   = retry_q + 8'd1;
                           tx_load_s = 8'h01;
                        end else begin
                           idle_d    = 1'b0;
                           ready_d   = 1'b1;
                           tx_load_s = 8'h00;
                        end
                     end
                     6'd58: begin
                        has_ext_d = 1'b1;
                        ext_d     = 32'hC0FF_8000;
                     end
                     6'd16: tx_load_s = {7'd0, idle_q};
                     6'd17, 6'd24: begin
                        if (idle_q) begin
                           tx_load_s = 8'h05;
                        end else if (arg_q >= 32'(NUM_BLOCKS)) begin
                           tx_load_s = 8'h20;
                        end else begin
                           tx_load_s = 8'h00;
                           data_ok_d = 1'b1;
                        end
                     end
                     default: tx_load_s = {5'd0, 1'b1, 1'b0, idle_q};
                  endcase
               end
               RESP: begin
                  if (has_ext_q && (byte_cnt_q < 10'd4)) begin
                     tx_load_s  = ext_q[31:24];
                     ext_d      = {ext_q[23:0], 8'h00};
                     byte_cnt_d = byte_cnt_q + 10'd1;
                  end else begin
                     byte_cnt_d = 10'd0;
                     if (data_ok_q && (cmd_q == 6'd17)) begin
                        state_d = RD_TOKEN;
                     end else if (data_ok_q && (cmd_q == 6'd24)) begin
                        state_d = WR_WAIT;
                     end else begin
                        state_d = WAIT_CMD;
                     end
                  end
               end
               RD_TOKEN: begin
                  tx_load_s  = 8'hFE;
                  byte_cnt_d = 10'd0;
                  state_d    = RD_DATA;
               end
               RD_DATA: begin
                  tx_load_s = mem_rdata;
                  if (byte_cnt_q == 10'd511) begin
                     byte_cnt_d = 10'd0;
                     state_d    = RD_CRC;
                  end else begin
                     byte_cnt_d = byte_cnt_q + 10'd1;
                  end
               end
               RD_CRC: begin
                  if (byte_cnt_q == 10'd1) begin
                     byte_cnt_d = 10'd0;
                     state_d    = WAIT_CMD;
                  end else begin
                     byte_cnt_d = byte_cnt_q + 10'd1;
                  end
               end
               WR_WAIT: begin
                  if (rx_byte_s == 8'hFE) begin
                     byte_cnt_d = 10'd0;
                     state_d    = WR_DATA;
                  end else if (rx_byte_s == 8'hFF) begin
                     state_d = WR_WAIT;
                  end else begin
                     state_d = WAIT_CMD;
                  end
               end
               WR_DATA: begin
                  mem_we_d    = 1'b1;
                  mem_addr_d  = blk_addr(arg_q[22:0], byte_cnt_q);
                  mem_wdata_d = rx_byte_s;
                  if (byte_cnt_q == 10'd511) begin
                     byte_cnt_d = 10'd0;
                     state_d    = WR_CRC;
                  end else begin
                     byte_cnt_d = byte_cnt_q + 10'd1;
                  end
               end
               WR_CRC: begin
                  if (byte_cnt_q == 10'd1) begin
                     tx_load_s  = 8'h05;
                     byte_cnt_d = 10'd0;
                     state_d    = WR_RESP;
                  end else begin
                     byte_cnt_d = byte_cnt_q + 10'd1;
                  end
               end
               WR_RESP: begin
                  tx_load_s  = 8'h00;
                  byte_cnt_d = 10'd0;
                  state_d    = WR_BUSY;
               end
               WR_BUSY: begin
                  if (byte_cnt_q == 10'(BUSY_BYTES - 1)) begin
                     byte_cnt_d = 10'd0;
                     state_d    = WAIT_CMD;
                  end else begin
                     tx_load_s  = 8'h00;
                     byte_cnt_d = byte_cnt_q + 10'd1;
                  end
               end
               default: state_d = WAIT_CMD;
            endcase
            tx_shift_d = tx_load_s;
         end else begin
            byte_done_s = 1'b0;
         end
      end

      // Read address runs one byte ahead so mem_rdata is settled long before the load.
      if (state_d == RD_DATA) begin
         mem_addr_d = blk_addr(arg_q[22:0], byte_cnt_d);
      end else begin
         mem_we_d = mem_we_d;
      end
   end

   // Input synchronizers and protocol state registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         sclk_meta_q <= 1'b0;
         sclk_sync_q <= 1'b0;
         sclk_prev_q <= 1'b0;
         cs_meta_q   <= 1'b1;
         cs_sync_q   <= 1'b1;
         mosi_meta_q <= 1'b1;
         mosi_sync_q <= 1'b1;
         state_q     <= WAIT_CMD;
         bit_cnt_q   <= 3'd0;
         rx_shift_q  <= 7'd0;
         tx_shift_q  <= 8'hFF;
         miso_q      <= 1'b1;
         byte_cnt_q  <= 10'd0;
         cmd_q       <= 6'd0;
         arg_q       <= 32'd0;
         ext_q       <= 32'd0;
         has_ext_q   <= 1'b0;
         data_ok_q   <= 1'b0;
         app_q       <= 1'b0;
         idle_q      <= 1'b0;
         ready_q     <= 1'b0;
         retry_q     <= 8'd0;
         mem_addr_q  <= '0;
         mem_wdata_q <= 8'd0;
         mem_we_q    <= 1'b0;
      end else begin
         sclk_meta_q <= sclk;
         sclk_sync_q <= sclk_meta_q;
         sclk_prev_q <= sclk_sync_q;
         cs_meta_q   <= cs;
         cs_sync_q   <= cs_meta_q;
         mosi_meta_q <= mosi;
         mosi_sync_q <= mosi_meta_q;
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         rx_shift_q  <= rx_shift_d;
         tx_shift_q  <= tx_shift_d;
         miso_q      <= miso_d;
         byte_cnt_q  <= byte_cnt_d;
         cmd_q       <= cmd_d;
         arg_q       <= arg_d;
         ext_q       <= ext_d;
         has_ext_q   <= has_ext_d;
         data_ok_q   <= data_ok_d;
         app_q       <= app_d;
         idle_q      <= idle_d;
         ready_q     <= ready_d;
         retry_q     <= retry_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_we_q    <= mem_we_d;
      end
   end

   assign miso       = miso_q;
   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = mem_wdata_q;
   assign mem_we     = mem_we_q;
   assign card_ready = ready_q;
   assign last_cmd   = cmd_q;
   assign debug      = {4'd0, state_q, byte_cnt_q, bit_cnt_q, idle_q, 10'd0};

endmodule

// File: tb/tb_sd_spi_card_responder.sv
// Directed bench for sd_spi_card_responder: drives SPI mode-0 frames as the host and
// checks every response byte, the memory image and the write-strobe count.
module tb_sd_spi_card_responder;

   localparam int MEM_AW = 15;

   logic              clk;
   logic              rst;
   logic              cs;
   logic              sclk;
   logic              mosi;
   logic              miso;
   logic [MEM_AW-1:0] mem_addr;
   logic [7:0]        mem_rdata;
   logic [7:0]        mem_wdata;
   logic              mem_we;
   logic              card_ready;
   logic [5:0]        last_cmd;
   logic [31:0]       debug;

   logic [7:0] mem [0:(1<<MEM_AW)-1];
   int         we_cnt;
   int         checks;
   int         errors;

   sd_spi_card_responder #(
      .NUM_BLOCKS(64), .MEM_AW(MEM_AW), .ACMD41_RETRIES(2), .BUSY_BYTES(4)
   ) dut (
      .clk(clk), .rst(rst), .cs(cs), .sclk(sclk), .mosi(mosi), .miso(miso),
      .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_wdata(mem_wdata),
      .mem_we(mem_we), .card_ready(card_ready), .last_cmd(last_cmd), .debug(debug)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // External byte memory, one clock read latency.
   always @(posedge clk) begin
      if (mem_we) begin
         mem[mem_addr] <= mem_wdata;
         we_cnt <= we_cnt + 1;
      end
      mem_rdata <= mem[mem_addr];
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic spi_xfer(input logic [7:0] tx, output logic [7:0] rx);
      for (int i = 7; i >= 0; i--) begin
         mosi = tx[i];
         repeat (4) @(negedge clk);
         sclk = 1'b1;
         rx[i] = miso;
         repeat (4) @(negedge clk);
         sclk = 1'b0;
      end
      mosi = 1'b1;
   endtask

   task automatic send(input logic [7:0] b);
      logic [7:0] r;
      spi_xfer(b, r);
   endtask

   task automatic send_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [7:0] crc);
      send({2'b01, idx});
      send(arg[31:24]);
      send(arg[23:16]);
      send(arg[15:8]);
      send(arg[7:0]);
      send(crc);
   endtask

   task automatic rd_chk(input string tag, input logic [7:0] exp);
      logic [7:0] r;
      spi_xfer(8'hFF, r);
      check(tag, {24'd0, r}, {24'd0, exp});
   endtask

   initial begin
      logic [7:0] acmd_exp [3];
      int         we_base;
      checks = 0;
      errors = 0;
      we_cnt = 0;
      rst  = 1'b1;
      cs   = 1'b1;
      sclk = 1'b0;
      mosi = 1'b1;
      acmd_exp[0] = 8'h01;
      acmd_exp[1] = 8'h01;
      acmd_exp[2] = 8'h00;
      repeat (4) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      check("rst_miso", {31'd0, miso}, 32'd1);
      check("rst_addr", {17'd0, mem_addr}, 32'd0);
      check("rst_we", {31'd0, mem_we}, 32'd0);
      check("rst_wdata", {24'd0, mem_wdata}, 32'd0);
      check("rst_ready", {31'd0, card_ready}, 32'd0);
      check("rst_last", {26'd0, last_cmd}, 32'd0);
      check("rst_debug", debug, 32'd0);

      cs = 1'b0;
      repeat (4) @(negedge clk);

      send_cmd(6'd0, 32'h0, 8'h95);
      rd_chk("cmd0_ncr", 8'hFF);
      rd_chk("cmd0_r1", 8'h01);

      send_cmd(6'd8, 32'h0000_01AA, 8'h87);
      rd_chk("cmd8_ncr", 8'hFF);
      rd_chk("cmd8_r1", 8'h01);
      rd_chk("cmd8_b1", 8'h00);
      rd_chk("cmd8_b2", 8'h00);
      rd_chk("cmd8_b3", 8'h01);
      rd_chk("cmd8_b4", 8'hAA);
      check("cmd8_last", {26'd0, last_cmd}, 32'd8);

      send_cmd(6'd17, 32'd3, 8'hFF);
      rd_chk("rd_idle_ncr", 8'hFF);
      rd_chk("rd_idle_r1", 8'h05);
      rd_chk("rd_idle_notok", 8'hFF);

      send_cmd(6'd13, 32'd0, 8'hFF);
      rd_chk("cmd13_idle_ncr", 8'hFF);
      rd_chk("cmd13_idle_r1", 8'h05);

      send_cmd(6'd41, 32'h4000_0000, 8'hFF);
      rd_chk("cmd41_noapp_ncr", 8'hFF);
      rd_chk("cmd41_noapp_r1", 8'h05);

      for (int k = 0; k < 3; k++) begin
         send_cmd(6'd55, 32'd0, 8'hFF);
         rd_chk($sformatf("cmd55_%0d_ncr", k), 8'hFF);
         rd_chk($sformatf("cmd55_%0d_r1", k), 8'h01);
         send_cmd(6'd41, 32'h4000_0000, 8'hFF);
         rd_chk($sformatf("acmd41_%0d_ncr", k), 8'hFF);
         rd_chk($sformatf("acmd41_%0d_r1", k), acmd_exp[k]);
         check($sformatf("acmd41_%0d_ready", k), {31'd0, card_ready}, (k == 2) ? 32'd1 : 32'd0);
      end

      send_cmd(6'd58, 32'd0, 8'hFF);
      rd_chk("cmd58_ncr", 8'hFF);
      rd_chk("cmd58_r1", 8'h00);
      rd_chk("cmd58_b1", 8'hC0);
      rd_chk("cmd58_b2", 8'hFF);
      rd_chk("cmd58_b3", 8'h80);
      rd_chk("cmd58_b4", 8'h00);

      send_cmd(6'd13, 32'd0, 8'hFF);
      rd_chk("cmd13_ncr", 8'hFF);
      rd_chk("cmd13_r1", 8'h04);

      send_cmd(6'd16, 32'd512, 8'hFF);
      rd_chk("cmd16_ncr", 8'hFF);
      rd_chk("cmd16_r1", 8'h00);

      // Write block 3 with byte i = i & 0xFF.
      we_base = we_cnt;
      send_cmd(6'd24, 32'd3, 8'hFF);
      rd_chk("wr_ncr", 8'hFF);
      rd_chk("wr_r1", 8'h00);
      send(8'hFE);
      for (int i = 0; i < 512; i++) begin
         send(8'(i));
      end
      send(8'hFF);
      send(8'hFF);
      rd_chk("wr_dresp", 8'h05);
      for (int i = 0; i < 4; i++) begin
         rd_chk($sformatf("wr_busy_%0d", i), 8'h00);
      end
      rd_chk("wr_done", 8'hFF);
      check("wr_we_pulses", we_cnt - we_base, 32'd512);
      for (int i = 0; i < 512; i++) begin
         check($sformatf("mem_%0h", 16'h600 + i), {24'd0, mem[15'h600 + 15'(i)]}, {24'd0, 8'(i)});
      end

      send_cmd(6'd17, 32'd3, 8'hFF);
      rd_chk("rd_ncr", 8'hFF);
      rd_chk("rd_r1", 8'h00);
      rd_chk("rd_gap", 8'hFF);
      rd_chk("rd_token", 8'hFE);
      for (int i = 0; i < 512; i++) begin
         rd_chk($sformatf("rd_data_%0d", i), 8'(i));
      end
      rd_chk("rd_crc0", 8'hFF);
      rd_chk("rd_crc1", 8'hFF);
      rd_chk("rd_after", 8'hFF);

      send_cmd(6'd17, 32'd64, 8'hFF);
      rd_chk("rd_oob_ncr", 8'hFF);
      rd_chk("rd_oob_r1", 8'h20);
      rd_chk("rd_oob_notok0", 8'hFF);
      rd_chk("rd_oob_notok1", 8'hFF);

      // Abandon a read partway through the block.
      send_cmd(6'd17, 32'd3, 8'hFF);
      rd_chk("abort_ncr", 8'hFF);
      rd_chk("abort_r1", 8'h00);
      rd_chk("abort_gap", 8'hFF);
      rd_chk("abort_token", 8'hFE);
      for (int i = 0; i < 10; i++) begin
         rd_chk($sformatf("abort_data_%0d", i), 8'(i));
      end
      cs = 1'b1;
      repeat (10) @(negedge clk);
      check("abort_miso", {31'd0, miso}, 32'd1);
      check("abort_debug", debug, 32'd0);
      check("abort_ready", {31'd0, card_ready}, 32'd1);
      cs = 1'b0;
      repeat (4) @(negedge clk);

      send_cmd(6'd0, 32'h0, 8'h95);
      rd_chk("recov_ncr", 8'hFF);
      rd_chk("recov_r1", 8'h01);
      check("recov_ready", {31'd0, card_ready}, 32'd0);
      check("recov_debug", debug, 32'h0000_0400);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
